// File: rtl/mem_req_stage.sv
// Memory-request stage: latches the EXE result, drives the data_sram address/write request and hands off to mem_ack_stage.
// Optional MEM_ADDR_EXC_EN: misaligned lh/lhu/sh/lw/sw raise AdEL/AdES instead of issuing a request.
module mem_req_stage #(
    parameter int ES_TO_RS_BUS_WD = 147,
    parameter int RS_TO_MS_BUS_WD = 113
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       es_to_rs_valid,
    input  logic [ES_TO_RS_BUS_WD-1:0] es_to_rs_bus,
    output logic                       rs_allowin,
    input  logic                       ms_allowin,
    output logic                       rs_to_ms_valid,
    output logic [RS_TO_MS_BUS_WD-1:0] rs_to_ms_bus,
    output logic                       rs_loading,
    output logic [42:0]                rs_reg,
    output logic                       data_sram_req,
    output logic                       data_sram_wr,
    output logic [1:0]                 data_sram_size,
    output logic [31:0]                data_sram_addr,
    output logic [3:0]                 data_sram_wstrb,
    output logic [31:0]                data_sram_wdata,
    input  logic                       data_sram_addr_ok
`ifdef MEM_ADDR_EXC_EN
   ,output logic                       rs_ex
   ,output logic [4:0]                 rs_ex_code
   ,output logic [31:0]                rs_badvaddr
`endif
);

    logic                       rs_valid_q, rs_valid_d;
    logic [ES_TO_RS_BUS_WD-1:0] rs_bus_q;
    logic                       addr_acc_q, addr_acc_d;

    logic        inst_mfc0, gr_we_raw, gr_we;
    logic [31:0] c0_rdata, alu_result, rt_value, pc;
    logic [6:0]  load_op;
    logic [4:0]  store_op, dest;
    logic [1:0]  a;
    logic        is_load_raw, is_store_raw, is_load, is_store, is_mem;
    logic        addr_err, rs_ready_go, entering;

    assign {inst_mfc0, c0_rdata, load_op, store_op, gr_we_raw, dest,
            alu_result, rt_value, pc} = rs_bus_q;
    assign a = alu_result[1:0];

    assign is_load_raw  = |load_op;
    assign is_store_raw = |store_op;

`ifdef MEM_ADDR_EXC_EN
    assign addr_err = ((load_op[2] | load_op[3] | store_op[1]) & a[0])
                    | ((load_op[4] | store_op[2]) & (a != 2'b00));
    assign rs_ex       = rs_valid_q & addr_err;
    assign rs_ex_code  = is_load_raw ? 5'd4 : 5'd5;
    assign rs_badvaddr = alu_result;
`else
    assign addr_err = 1'b0;
`endif

    // A faulting access is turned into a plain non-mem op so it flows through without a request.
    assign is_load  = is_load_raw  & ~addr_err;
    assign is_store = is_store_raw & ~addr_err;
    assign gr_we    = gr_we_raw    & ~addr_err;
    assign is_mem   = is_load | is_store;

    // Gating with ms_allowin keeps at most one request outstanding past mem_ack_stage.
    assign data_sram_req  = rs_valid_q & is_mem & ~addr_acc_q & ms_allowin;
    assign rs_ready_go    = ~is_mem | addr_acc_q | (data_sram_req & data_sram_addr_ok);
    assign rs_allowin     = ~rs_valid_q | (rs_ready_go & ms_allowin);
    assign rs_to_ms_valid = rs_valid_q & rs_ready_go;
    assign entering       = es_to_rs_valid & rs_allowin;

    assign rs_valid_d = rs_allowin ? es_to_rs_valid : rs_valid_q;
    // Accepted-without-transfer only when mem_ack_stage stalls; any free slot starts over.
    assign addr_acc_d = rs_allowin ? 1'b0
                      : (data_sram_req & data_sram_addr_ok) ? 1'b1 : addr_acc_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rs_valid_q <= 1'b0;
            addr_acc_q <= 1'b0;
        end else begin
            rs_valid_q <= rs_valid_d;
            addr_acc_q <= addr_acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (entering) rs_bus_q <= es_to_rs_bus;
    end

    always_comb begin
        data_sram_addr  = alu_result;
        data_sram_size  = 2'd2;
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = rt_value;
        if (load_op[0] | load_op[1]) begin
            data_sram_size = 2'd0;
        end else if (load_op[2] | load_op[3]) begin
            data_sram_size = 2'd1;
        end else if (load_op[5] | load_op[6]) begin
            data_sram_addr = {alu_result[31:2], 2'b00};
        end else if (store_op[0]) begin
            data_sram_size  = 2'd0;
            data_sram_wstrb = 4'b0001 << a;
            data_sram_wdata = {4{rt_value[7:0]}};
        end else if (store_op[1]) begin
            data_sram_size  = 2'd1;
            data_sram_wstrb = a[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{rt_value[15:0]}};
        end else if (store_op[2]) begin
            data_sram_wstrb = 4'b1111;
        end else if (store_op[3]) begin
            data_sram_addr = {alu_result[31:2], 2'b00};
            case (a)
                2'd0:    begin data_sram_wstrb = 4'b0001; data_sram_wdata = rt_value >> 24; end
                2'd1:    begin data_sram_wstrb = 4'b0011; data_sram_wdata = rt_value >> 16; end
                2'd2:    begin data_sram_wstrb = 4'b0111; data_sram_wdata = rt_value >> 8;  end
                default: begin data_sram_wstrb = 4'b1111; data_sram_wdata = rt_value;       end
            endcase
        end else if (store_op[4]) begin
            data_sram_addr = {alu_result[31:2], 2'b00};
            case (a)
                2'd0:    begin data_sram_wstrb = 4'b1111; data_sram_wdata = rt_value;       end
                2'd1:    begin data_sram_wstrb = 4'b1110; data_sram_wdata = rt_value << 8;  end
                2'd2:    begin data_sram_wstrb = 4'b1100; data_sram_wdata = rt_value << 16; end
                default: begin data_sram_wstrb = 4'b1000; data_sram_wdata = rt_value << 24; end
            endcase
        end
        if (!is_store) data_sram_wstrb = 4'b0000;
    end

    assign data_sram_wr = is_store;

    assign rs_to_ms_bus = {inst_mfc0, c0_rdata, is_load, is_store, load_op, is_load,
                           gr_we, dest, alu_result, pc};
    assign rs_loading   = rs_valid_q & is_load;
    assign rs_reg       = {is_load, {4{gr_we & rs_valid_q}}, inst_mfc0 & rs_valid_q,
                           dest & {5{rs_valid_q}}, alu_result};

endmodule

// File: tb/tb_mem_req_stage.sv
// Scoreboard bench for mem_req_stage: expected requests and downstream payloads are queued at issue and
// popped by monitors whenever the DUT presents an accepted request or a transfer.
module tb_mem_req_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         es_to_rs_valid;
    logic [146:0] es_to_rs_bus;
    logic         rs_allowin;
    logic         ms_allowin;
    logic         rs_to_ms_valid;
    logic [112:0] rs_to_ms_bus;
    logic         rs_loading;
    logic [42:0]  rs_reg;
    logic         data_sram_req, data_sram_wr;
    logic [1:0]   data_sram_size;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    logic [3:0]   data_sram_wstrb;
    logic         data_sram_addr_ok;
`ifdef MEM_ADDR_EXC_EN
    logic         rs_ex;
    logic [4:0]   rs_ex_code;
    logic [31:0]  rs_badvaddr;
`endif

    mem_req_stage dut (
        .clk(clk), .resetn(resetn),
        .es_to_rs_valid(es_to_rs_valid), .es_to_rs_bus(es_to_rs_bus),
        .rs_allowin(rs_allowin), .ms_allowin(ms_allowin),
        .rs_to_ms_valid(rs_to_ms_valid), .rs_to_ms_bus(rs_to_ms_bus),
        .rs_loading(rs_loading), .rs_reg(rs_reg),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok)
`ifdef MEM_ADDR_EXC_EN
       ,.rs_ex(rs_ex), .rs_ex_code(rs_ex_code), .rs_badvaddr(rs_badvaddr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        chk_wd;
    } req_t;

    req_t         req_q[$];
    logic [112:0] bus_q[$];
    int           n_pass = 0, n_total = 0;
    int           ok_delay = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [146:0] ibus(logic mfc0, logic [31:0] c0, logic [6:0] lop, logic [4:0] sop,
                                          logic we, logic [4:0] dst, logic [31:0] alu, logic [31:0] rt,
                                          logic [31:0] pc);
        return {mfc0, c0, lop, sop, we, dst, alu, rt, pc};
    endfunction

    function automatic logic [112:0] obus(logic mfc0, logic [31:0] c0, logic ld, logic st, logic [6:0] lop,
                                          logic we, logic [4:0] dst, logic [31:0] alu, logic [31:0] pc);
        return {mfc0, c0, ld, st, lop, ld, we, dst, alu, pc};
    endfunction

    // Responder: raises addr_ok once req has been seen for ok_delay cycles.
    initial begin
        int cnt;
        cnt = 0;
        data_sram_addr_ok = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!resetn) begin
                cnt = 0;
                data_sram_addr_ok = 1'b0;
            end else if (data_sram_req) begin
                data_sram_addr_ok = (cnt >= ok_delay);
                cnt = data_sram_addr_ok ? 0 : cnt + 1;
            end else begin
                data_sram_addr_ok = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && data_sram_req && data_sram_addr_ok) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", 1'b1, 1'b0);
            end else begin
                req_t e;
                e = req_q.pop_front();
                chk("req_addr", data_sram_addr, e.addr);
                chk("req_size", data_sram_size, e.size);
                chk("req_wr", data_sram_wr, e.wr);
                chk("req_wstrb", data_sram_wstrb, e.wstrb);
                if (e.chk_wd) chk("req_wdata", data_sram_wdata, e.wdata);
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && rs_to_ms_valid && ms_allowin) begin
            if (bus_q.size() == 0) chk("unexpected_xfer", 1'b1, 1'b0);
            else chk("ms_bus", rs_to_ms_bus, bus_q.pop_front());
        end
    end

    task automatic issue(input logic [146:0] b);
        int k;
        @(posedge clk);
        #1;
        es_to_rs_valid = 1'b1;
        es_to_rs_bus   = b;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rs_allowin) break;
        end
        if (k == 50) chk("allowin_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        es_to_rs_valid = 1'b0;
    endtask

    function automatic req_t mk(logic [31:0] ad, logic [1:0] sz, logic wr, logic [3:0] st,
                                logic [31:0] wd, logic cw);
        req_t r;
        r.addr = ad; r.size = sz; r.wr = wr; r.wstrb = st; r.wdata = wd; r.chk_wd = cw;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        es_to_rs_valid = 1'b0;
        es_to_rs_bus = '0;
        ms_allowin = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_allowin", rs_allowin, 1'b1);
        chk("rst_req", data_sram_req, 1'b0);
        chk("rst_valid", rs_to_ms_valid, 1'b0);
        chk("rst_loading", rs_loading, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // addu-type op
        bus_q.push_back(obus(0, 32'h0, 0, 0, 7'h0, 1, 5'd5, 32'h1111_2222, 32'hBFC0_0000));
        issue(ibus(0, 32'h0, 7'h0, 5'h0, 1, 5'd5, 32'h1111_2222, 32'h0, 32'hBFC0_0000));
        @(negedge clk);
        chk("addu_valid", rs_to_ms_valid, 1'b1);
        chk("addu_req", data_sram_req, 1'b0);
        chk("addu_rs_reg", rs_reg, {1'b0, 4'hF, 1'b0, 5'd5, 32'h1111_2222});

        // lw with addr_ok held low three cycles
        ok_delay = 3;
        req_q.push_back(mk(32'h1000_0004, 2'd2, 0, 4'b0000, 32'h0, 0));
        bus_q.push_back(obus(0, 32'h0, 1, 0, 7'b0010000, 1, 5'd8, 32'h1000_0004, 32'hBFC0_0004));
        issue(ibus(0, 32'h0, 7'b0010000, 5'h0, 1, 5'd8, 32'h1000_0004, 32'h0, 32'hBFC0_0004));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("lw_req_c%0d", i), data_sram_req, 1'b1);
            chk($sformatf("lw_allowin_c%0d", i), rs_allowin, (i == 3));
        end

        ok_delay = 0;
        // sb a=2
        req_q.push_back(mk(32'h2000_0002, 2'd0, 1, 4'b0100, 32'h7878_7878, 1));
        bus_q.push_back(obus(0, 32'h0, 0, 1, 7'h0, 0, 5'd0, 32'h2000_0002, 32'hBFC0_0008));
        issue(ibus(0, 32'h0, 7'h0, 5'b00001, 0, 5'd0, 32'h2000_0002, 32'h1234_5678, 32'hBFC0_0008));
        // swl a=1
        req_q.push_back(mk(32'h3000_0000, 2'd2, 1, 4'b0011, 32'h0000_AABB, 1));
        bus_q.push_back(obus(0, 32'h0, 0, 1, 7'h0, 0, 5'd0, 32'h3000_0001, 32'hBFC0_000C));
        issue(ibus(0, 32'h0, 7'h0, 5'b01000, 0, 5'd0, 32'h3000_0001, 32'hAABB_CCDD, 32'hBFC0_000C));
        // swr a=3
        req_q.push_back(mk(32'h3000_0000, 2'd2, 1, 4'b1000, 32'hDD00_0000, 1));
        bus_q.push_back(obus(0, 32'h0, 0, 1, 7'h0, 0, 5'd0, 32'h3000_0003, 32'hBFC0_0010));
        issue(ibus(0, 32'h0, 7'h0, 5'b10000, 0, 5'd0, 32'h3000_0003, 32'hAABB_CCDD, 32'hBFC0_0010));
        // sh a=2
        req_q.push_back(mk(32'h4000_0002, 2'd1, 1, 4'b1100, 32'h5678_5678, 1));
        bus_q.push_back(obus(0, 32'h0, 0, 1, 7'h0, 0, 5'd0, 32'h4000_0002, 32'hBFC0_0014));
        issue(ibus(0, 32'h0, 7'h0, 5'b00010, 0, 5'd0, 32'h4000_0002, 32'h1234_5678, 32'hBFC0_0014));
        // sw
        req_q.push_back(mk(32'h4000_0008, 2'd2, 1, 4'b1111, 32'hCAFE_F00D, 1));
        bus_q.push_back(obus(0, 32'h0, 0, 1, 7'h0, 0, 5'd0, 32'h4000_0008, 32'hBFC0_0018));
        issue(ibus(0, 32'h0, 7'h0, 5'b00100, 0, 5'd0, 32'h4000_0008, 32'hCAFE_F00D, 32'hBFC0_0018));
        // lbu, with an mfc0-style payload riding along
        req_q.push_back(mk(32'h5000_0003, 2'd0, 0, 4'b0000, 32'h0, 0));
        bus_q.push_back(obus(1, 32'hDEAD_BEEF, 1, 0, 7'b0000010, 1, 5'd9, 32'h5000_0003, 32'hBFC0_001C));
        issue(ibus(1, 32'hDEAD_BEEF, 7'b0000010, 5'h0, 1, 5'd9, 32'h5000_0003, 32'h0, 32'hBFC0_001C));
        // lwr: word-aligned address
        req_q.push_back(mk(32'h5000_0004, 2'd2, 0, 4'b0000, 32'h0, 0));
        bus_q.push_back(obus(0, 32'h0, 1, 0, 7'b1000000, 1, 5'd10, 32'h5000_0006, 32'hBFC0_0020));
        issue(ibus(0, 32'h0, 7'b1000000, 5'h0, 1, 5'd10, 32'h5000_0006, 32'h0, 32'hBFC0_0020));

        // load held back by mem_ack_stage
        repeat (2) @(posedge clk);
        #1;
        ms_allowin = 1'b0;
        req_q.push_back(mk(32'h6000_0002, 2'd1, 0, 4'b0000, 32'h0, 0));
        bus_q.push_back(obus(0, 32'h0, 1, 0, 7'b0000100, 1, 5'd11, 32'h6000_0002, 32'hBFC0_0024));
        issue(ibus(0, 32'h0, 7'b0000100, 5'h0, 1, 5'd11, 32'h6000_0002, 32'h0, 32'hBFC0_0024));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_req", data_sram_req, 1'b0);
            chk("stall_loading", rs_loading, 1'b1);
            chk("stall_allowin", rs_allowin, 1'b0);
        end
        @(posedge clk); #1;
        ms_allowin = 1'b1;
        @(negedge clk);
        chk("release_valid", rs_to_ms_valid, 1'b1);
        chk("release_allowin", rs_allowin, 1'b1);

        // reset pulse in the middle of a pending request
        ok_delay = 10;
        issue(ibus(0, 32'h0, 7'b0010000, 5'h0, 1, 5'd12, 32'h7000_0000, 32'h0, 32'hBFC0_0028));
        @(negedge clk);
        chk("prerst_req", data_sram_req, 1'b1);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_req", data_sram_req, 1'b0);
        chk("midrst_valid", rs_to_ms_valid, 1'b0);
        chk("midrst_loading", rs_loading, 1'b0);
        chk("midrst_allowin", rs_allowin, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        ok_delay = 0;

        bus_q.push_back(obus(0, 32'h0, 0, 0, 7'h0, 1, 5'd13, 32'h0000_0042, 32'hBFC0_002C));
        issue(ibus(0, 32'h0, 7'h0, 5'h0, 1, 5'd13, 32'h0000_0042, 32'h0, 32'hBFC0_002C));

`ifdef MEM_ADDR_EXC_EN
        // misaligned lw: no request, flagged as AdEL, load/write-back suppressed
        bus_q.push_back(obus(0, 32'h0, 0, 0, 7'b0010000, 0, 5'd14, 32'h8000_0002, 32'hBFC0_0030));
        issue(ibus(0, 32'h0, 7'b0010000, 5'h0, 1, 5'd14, 32'h8000_0002, 32'h0, 32'hBFC0_0030));
        @(negedge clk);
        chk("exc_req", data_sram_req, 1'b0);
        chk("exc_ex", rs_ex, 1'b1);
        chk("exc_code", rs_ex_code, 5'd4);
        chk("exc_badv", rs_badvaddr, 32'h8000_0002);
`endif

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("req_q_drained", req_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_req_stage.md
Name: mem_req_stage

Overview:
- Memory-request pipeline stage between EXE and mem_ack_stage.
- Latches the EXE result and issues the data_sram address/write request for loads and stores, generating size, byte strobes and lane-shifted store data for all byte/half/word and unaligned (lwl/lwr/swl/swr) forms.
- Passes the 113-bit RS_TO_MS bus downstream and exports forwarding/load-use information to decode.

Parameters:
ES_TO_RS_BUS_WD, 147, input bus width: {inst_mfc0, c0_rdata[31:0], load_op[6:0], store_op[4:0], gr_we, dest[4:0], alu_result[31:0], rt_value[31:0], pc[31:0]}
RS_TO_MS_BUS_WD, 113, output bus width: {inst_mfc0, c0_rdata, is_load, is_store, load_op[6:0], res_from_mem, gr_we, dest, alu_result, pc}

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
es_to_rs_valid  in  1  EXE has a valid instruction
es_to_rs_bus  in  ES_TO_RS_BUS_WD  EXE payload
rs_allowin  out  1  stage can accept from EXE
ms_allowin  in  1  mem_ack_stage can accept
rs_to_ms_valid  out  1  valid to mem_ack_stage
rs_to_ms_bus  out  RS_TO_MS_BUS_WD  payload to mem_ack_stage
rs_loading  out  1  valid load in this stage
rs_reg  out  43  forward: {is_load, rf_we[3:0], inst_mfc0, dest[4:0], alu_result[31:0]}
data_sram_req  out  1  request
data_sram_wr  out  1  1 = store
data_sram_size  out  2  0 = byte, 1 = half, 2 = word
data_sram_addr  out  32  address
data_sram_wstrb  out  4  byte strobes
data_sram_wdata  out  32  store data
data_sram_addr_ok  in  1  request accepted this cycle

Behaviour:
- Op encoding:
  - load_op[0..6] = lb, lbu, lh, lhu, lw, lwl, lwr.
  - store_op[0..4] = sb, sh, sw, swl, swr.
  - is_load = |load_op; is_store = |store_op; is_mem = is_load | is_store; res_from_mem = is_load.
- Registers:
  - rs_valid: async reset to 0; when rs_allowin, loaded with es_to_rs_valid.
  - Bus register: loaded when es_to_rs_valid && rs_allowin; not reset.
  - addr_acc flag: async reset to 0; set on data_sram_req && data_sram_addr_ok; cleared whenever a new instruction enters.
- Request:
  - data_sram_req = rs_valid & is_mem & !addr_acc & ms_allowin, purely combinational.
  - Gating with ms_allowin caps outstanding requests at one beyond mem_ack_stage, so data_ok always returns to the instruction that mem_ack_stage holds.
  - req may drop without addr_ok; the bus bridge samples only req & addr_ok.
- Handshake:
  - rs_ready_go = !is_mem | addr_acc | (data_sram_req & data_sram_addr_ok).
  - rs_allowin = !rs_valid | (rs_ready_go & ms_allowin).
  - rs_to_ms_valid = rs_valid & rs_ready_go.
  - Non-mem ops pass in 1 cycle. Mem ops leave in the addr_ok cycle; minimum latency is 1 cycle.
- Effective state machine (EMPTY/REQ/ACC):
  - EMPTY -> REQ on a mem op entering.
  - REQ -> ACC on addr_ok when ms_allowin is 0 (unreachable with current gating, but retained).
  - ACC/REQ -> EMPTY or a new op on transfer.
- Addressing:
  - Byte/half/word ops: addr = alu_result; size = 0/1/2.
  - lwl/lwr/swl/swr: addr = {alu_result[31:2], 2'b00}, size = 2.
- Store strobes/data, by a = alu_result[1:0]:
  - sb: wstrb = 1 << a; wdata = {4{rt[7:0]}}.
  - sh: wstrb = 0011 (a = 0) or 1100 (a = 2); wdata = {2{rt[15:0]}}.
  - sw: wstrb = 1111; wdata = rt.
  - swl, a = 0/1/2/3: wstrb = 0001 / 0011 / 0111 / 1111; wdata = rt >> 24 / 16 / 8 / 0.
  - swr, a = 0/1/2/3: wstrb = 1111 / 1110 / 1100 / 1000; wdata = rt << 0 / 8 / 16 / 24.
  - Loads: wr = 0, wstrb = 0000.
- Forwarding: rf_we = {4{gr_we & rs_valid}}; rs_reg fields dest and inst_mfc0 are masked by rs_valid; rs_loading = rs_valid & is_load.
- Outputs during reset: rs_valid = 0, so req, rs_to_ms_valid and rs_loading are 0 and rs_allowin = 1.
- resetn asserted mid-request: req drops the same instant; no pending state survives.

Optional Feature:
- Macro: MEM_ADDR_EXC_EN.
- Defined:
  - lh/lhu/sh with a[0] = 1, or lw/sw with a != 0, is an address error.
  - No request is issued; is_load, is_store and gr_we are forced to 0 on all outputs.
  - rs_ready_go = 1.
  - Extra outputs: rs_ex (1) = rs_valid & addr_err; rs_ex_code (5) = 4 for loads (AdEL), 5 for stores (AdES); rs_badvaddr (32) = alu_result.
- Undefined: no check is made, the extra ports are absent, and the address is issued as is.

Test Plan:
- addu-type op (gr_we = 1, no mem), ms_allowin = 1 -> rs_to_ms_valid in the next cycle, req stays 0, rs_reg.rf_we = 1111.
- lw at 0x1000_0004, addr_ok held low 3 cycles then high -> req high for 4 cycles with addr 0x1000_0004 and size 2; rs_allowin = 0 until the addr_ok cycle; bus is_load = 1.
- sb at a = 2, rt = 0x12345678 -> wr = 1, wstrb = 0100, wdata = 0x78787878, size 0.
- swl at 0x...01, rt = 0xAABBCCDD -> addr 0x...00, wstrb = 0011, wdata = 0x0000AABB; swr at a = 3 -> wstrb = 1000, wdata = 0xDD000000.
- Load pending with ms_allowin = 0 -> req = 0 and rs_loading = 1; when ms_allowin rises with addr_ok -> transfer in the same cycle. Pulse resetn low mid-request -> req, rs_to_ms_valid and rs_loading drop to 0 immediately.
- MEM_ADDR_EXC_EN defined, lw at 0x...02 -> req never asserts; rs_ex = 1, rs_ex_code = 4, rs_badvaddr = 0x...02; bus is_load = 0.
